vai_rx_demux: RTL and testbench

//  Upstream-to-downstream half of the sub-AFU multiplexing layer. Takes one registered CCI-P Rx

---
 rtl/vai_mux_pkg.sv | 82 ++++++++
 rtl/vai_rx_demux_if.sv | 24 ++
 rtl/vai_rx_route_stage.sv | 109 ++++++++++
 rtl/vai_rx_demux.sv | 93 +++++++++
 tb/tb_vai_rx_demux.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vai_mux_pkg.sv
// Shared types for the sub-AFU multiplexing layer (Tx arbiter and Rx demux).
// Holds a reduced CCI-P Rx port view, tag-field placement and route helpers.
package vai_mux_pkg;

    // mdata bits [15 -: TAG_BITS] carry the sub-AFU tag written by the Tx arbiter
    localparam int MDATA_TAG_MSB = 15;
    localparam int MAX_SUB_AFUS  = 8;
    localparam int PORT_W        = 3;
    localparam int CCIP_DATA_W   = 512;
    localparam int CCIP_HDR_W    = 28;

    // Tag width: max(1, clog2(n))
    function automatic int tag_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] port;
    } t_vai_route;

    // c0 read-response header; mdata sits in the low 16 bits
    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic [1:0]  rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c0_rsp_hdr;

    // c1 write-response header; format=1 marks a packed write response
    typedef struct packed {
        logic [1:0]  vc_used;
        logic        rsvd1;
        logic        hit_miss;
        logic        format;
        logic        rsvd0;
        logic [1:0]  cl_num;
        logic [3:0]  resp_type;
        logic [15:0] mdata;
    } t_ccip_c1_rsp_hdr;

    // MMIO request header overlaid on the same c0 header bits
    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_mmio_hdr;

    typedef struct packed {
        logic [CCIP_HDR_W-1:0]  hdr;
        logic [CCIP_DATA_W-1:0] data;
        logic                   rspValid;
        logic                   mmioRdValid;
        logic                   mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [CCIP_HDR_W-1:0] hdr;
        logic                  rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

    // Idle port: no valids, almost-full asserted so nobody transmits during reset
    function automatic t_if_ccip_Rx rx_idle();
        t_if_ccip_Rx r;
        r             = '0;
        r.c0TxAlmFull = 1'b1;
        r.c1TxAlmFull = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/vai_rx_demux_if.sv
// Rx-side bundle between the upstream CCI-P port and the sub-AFU ports.
interface vai_rx_demux_if
    import vai_mux_pkg::*;
#(
    parameter int NUM_SUB_AFUS = 3
);
    t_if_ccip_Rx                    up_RxPort;
    t_if_ccip_Rx [NUM_SUB_AFUS-1:0] afu_RxPort;
    logic [NUM_SUB_AFUS-1:0]        afu_SoftReset;
    logic                           route_err;
    logic [15:0]                    drop_cnt;

    // Upstream side: supplies the Rx port, observes the fan-out
    modport master (
        output up_RxPort,
        input  afu_RxPort, afu_SoftReset, route_err, drop_cnt
    );

    // Demux side
    modport slave (
        input  up_RxPort,
        output afu_RxPort, afu_SoftReset, route_err, drop_cnt
    );
endinterface

// File: rtl/vai_rx_route_stage.sv
// One registered decode/steer stage: picks a target port for c0 and c1,
// clears the routing bits, and gates only the valids per port.
module vai_rx_route_stage
    import vai_mux_pkg::*;
#(
    parameter int NUM_SUB_AFUS  = 3,
    parameter int MMIO_WIN_BITS = 12
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  t_if_ccip_Rx                    rx_in,
    output t_if_ccip_Rx [NUM_SUB_AFUS-1:0] rx_out,
    output logic                           c0_drop,
    output logic                           c1_drop,
    output logic                           mmio_bad
);
    localparam int          TB       = tag_bits(NUM_SUB_AFUS);
    localparam logic [15:0] WIN_MASK = 16'((32'd1 << MMIO_WIN_BITS) - 32'd1);

    logic [TB-1:0]                  c0_tag, c1_tag;
    logic [15:0]                    mmio_win;
    t_ccip_c0_mmio_hdr              mmio_hdr;
    t_vai_route                     c0_route, c1_route;
    t_if_ccip_Rx                    steered;
    t_if_ccip_Rx [NUM_SUB_AFUS-1:0] rx_d, rx_q;
    logic                           c0_drop_d, c1_drop_d, mmio_bad_d;
    logic                           c0_drop_q, c1_drop_q, mmio_bad_q;

    // Decode the route for each channel and rewrite the routing bits in the header
    always_comb begin
        steered    = rx_in;
        mmio_hdr   = t_ccip_c0_mmio_hdr'(rx_in.c0.hdr);
        c0_tag     = rx_in.c0.hdr[MDATA_TAG_MSB -: TB];
        c1_tag     = rx_in.c1.hdr[MDATA_TAG_MSB -: TB];
        mmio_win   = mmio_hdr.address >> MMIO_WIN_BITS;
        c0_route   = '0;
        c1_route   = '0;
        c0_drop_d  = 1'b0;
        c1_drop_d  = 1'b0;
        mmio_bad_d = 1'b0;

        if (rx_in.c0.rspValid) begin
            steered.c0.hdr[MDATA_TAG_MSB -: TB] = '0;
            if (32'(c0_tag) < NUM_SUB_AFUS) begin
                c0_route.valid = 1'b1;
                c0_route.port  = PORT_W'(c0_tag);
            end else begin
                c0_drop_d = 1'b1;
            end
        end else if (rx_in.c0.mmioRdValid || rx_in.c0.mmioWrValid) begin
            // Out-of-window requests still go somewhere (port 0) so reads get answered
            c0_route.valid = 1'b1;
            if (32'(mmio_win) < NUM_SUB_AFUS) begin
                c0_route.port    = PORT_W'(mmio_win);
                mmio_hdr.address = mmio_hdr.address & WIN_MASK;
                steered.c0.hdr   = mmio_hdr;
            end else begin
                mmio_bad_d = 1'b1;
            end
        end

        if (rx_in.c1.rspValid) begin
            steered.c1.hdr[MDATA_TAG_MSB -: TB] = '0;
            if (32'(c1_tag) < NUM_SUB_AFUS) begin
                c1_route.valid = 1'b1;
                c1_route.port  = PORT_W'(c1_tag);
            end else begin
                c1_drop_d = 1'b1;
            end
        end
    end

    // Fan the payload out unchanged to every port; only the selected port sees valids
    always_comb begin
        rx_d = '0;
        for (int p = 0; p < NUM_SUB_AFUS; p++) begin
            rx_d[p]                = steered;
            rx_d[p].c0.rspValid    = steered.c0.rspValid && c0_route.valid &&
                                     (c0_route.port == PORT_W'(p));
            rx_d[p].c0.mmioRdValid = steered.c0.mmioRdValid && c0_route.valid &&
                                     (c0_route.port == PORT_W'(p));
            rx_d[p].c0.mmioWrValid = steered.c0.mmioWrValid && c0_route.valid &&
                                     (c0_route.port == PORT_W'(p));
            rx_d[p].c1.rspValid    = steered.c1.rspValid && c1_route.valid &&
                                     (c1_route.port == PORT_W'(p));
        end
    end

    // Stage register; error pulses stay aligned with the steered beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_SUB_AFUS; p++) rx_q[p] <= rx_idle();
            c0_drop_q  <= 1'b0;
            c1_drop_q  <= 1'b0;
            mmio_bad_q <= 1'b0;
        end else begin
            rx_q       <= rx_d;
            c0_drop_q  <= c0_drop_d;
            c1_drop_q  <= c1_drop_d;
            mmio_bad_q <= mmio_bad_d;
        end
    end

    assign rx_out   = rx_q;
    assign c0_drop  = c0_drop_q;
    assign c1_drop  = c1_drop_q;
    assign mmio_bad = mmio_bad_q;

endmodule

// File: rtl/vai_rx_demux.sv
// Rx demux: steers one upstream CCI-P Rx port to NUM_SUB_AFUS downstream ports,
// generates per-AFU resets and keeps routing error statistics.
module vai_rx_demux
    import vai_mux_pkg::*;
#(
    parameter int NUM_SUB_AFUS    = 3,
    parameter int NUM_PIPE_STAGES = 0,
    parameter int MMIO_WIN_BITS   = 12,
    parameter int RESET_HOLD      = 16
)(
    input  logic          pClk,
    input  logic          SoftReset_n,
    vai_rx_demux_if.slave bus
);
    localparam int CNT_W = (RESET_HOLD < 1) ? 1 : $clog2(RESET_HOLD + 1);

    t_if_ccip_Rx [NUM_SUB_AFUS-1:0] route_rx;
    logic                           c0_drop, c1_drop, mmio_bad;
    logic [CNT_W-1:0]               hold_cnt_d, hold_cnt_q;
    logic                           rst_hold_d, rst_hold_q;
    logic                           route_err_d, route_err_q;
    logic [15:0]                    drop_cnt_d, drop_cnt_q;
    logic [16:0]                    drop_sum;

    vai_rx_route_stage #(
        .NUM_SUB_AFUS  (NUM_SUB_AFUS),
        .MMIO_WIN_BITS (MMIO_WIN_BITS)
    ) u_route (
        .clk      (pClk),
        .rst_n    (SoftReset_n),
        .rx_in    (bus.up_RxPort),
        .rx_out   (route_rx),
        .c0_drop  (c0_drop),
        .c1_drop  (c1_drop),
        .mmio_bad (mmio_bad)
    );

    generate
        if (NUM_PIPE_STAGES == 0) begin : g_no_pipe
            assign bus.afu_RxPort = route_rx;
        end else begin : g_pipe
            t_if_ccip_Rx [NUM_PIPE_STAGES-1:0][NUM_SUB_AFUS-1:0] pipe_q;

            // Plain delay stages; almFull travels with the beats so latency is uniform
            always_ff @(posedge pClk or negedge SoftReset_n) begin
                if (!SoftReset_n) begin
                    for (int s = 0; s < NUM_PIPE_STAGES; s++)
                        for (int p = 0; p < NUM_SUB_AFUS; p++)
                            pipe_q[s][p] <= rx_idle();
                end else begin
                    pipe_q[0] <= route_rx;
                    for (int s = 1; s < NUM_PIPE_STAGES; s++)
                        pipe_q[s] <= pipe_q[s-1];
                end
            end

            assign bus.afu_RxPort = pipe_q[NUM_PIPE_STAGES-1];
        end
    endgenerate

    // Hold counter runs down after reset release; all AFU resets drop together at 0
    always_comb begin
        hold_cnt_d = (hold_cnt_q != '0) ? hold_cnt_q - CNT_W'(1) : hold_cnt_q;
        rst_hold_d = (hold_cnt_d != '0);
    end

    // Sticky error flag and saturating drop counter (two drops per cycle possible)
    always_comb begin
        route_err_d = route_err_q | c0_drop | c1_drop | mmio_bad;
        drop_sum    = {1'b0, drop_cnt_q} + 17'(c0_drop) + 17'(c1_drop);
        drop_cnt_d  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Reset-hold and statistics state
    always_ff @(posedge pClk or negedge SoftReset_n) begin
        if (!SoftReset_n) begin
            hold_cnt_q  <= CNT_W'(RESET_HOLD);
            rst_hold_q  <= 1'b1;
            route_err_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            rst_hold_q  <= rst_hold_d;
            route_err_q <= route_err_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.afu_SoftReset = {NUM_SUB_AFUS{rst_hold_q}};
    assign bus.route_err     = route_err_q;
    assign bus.drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_vai_rx_demux.sv
// Directed bench for vai_rx_demux: N=3, N=4 and N=3 with two extra pipe stages,
// all fed from the same upstream stimulus.
module tb_vai_rx_demux;
    import vai_mux_pkg::*;

    logic        clk;
    logic        rst_n;
    t_if_ccip_Rx up;
    int          errors = 0;
    int          checks = 0;

    vai_rx_demux_if #(.NUM_SUB_AFUS(3)) if3  ();
    vai_rx_demux_if #(.NUM_SUB_AFUS(4)) if4  ();
    vai_rx_demux_if #(.NUM_SUB_AFUS(3)) if3p ();

    assign if3.up_RxPort  = up;
    assign if4.up_RxPort  = up;
    assign if3p.up_RxPort = up;

    vai_rx_demux #(.NUM_SUB_AFUS(3), .NUM_PIPE_STAGES(0), .MMIO_WIN_BITS(12), .RESET_HOLD(16))
        dut3 (.pClk(clk), .SoftReset_n(rst_n), .bus(if3));
    vai_rx_demux #(.NUM_SUB_AFUS(4), .NUM_PIPE_STAGES(0), .MMIO_WIN_BITS(12), .RESET_HOLD(16))
        dut4 (.pClk(clk), .SoftReset_n(rst_n), .bus(if4));
    vai_rx_demux #(.NUM_SUB_AFUS(3), .NUM_PIPE_STAGES(2), .MMIO_WIN_BITS(12), .RESET_HOLD(16))
        dut3p (.pClk(clk), .SoftReset_n(rst_n), .bus(if3p));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-port valid / almFull vectors for compact comparisons
    logic [2:0] c0v3, c1v3, mrv3, a0v3, c0v3p, c1v3p, mrv3p, a0v3p, a1v3p;
    logic [3:0] c1v4, mrv4;
    always_comb begin
        c0v3 = '0; c1v3 = '0; mrv3 = '0; a0v3 = '0;
        c0v3p = '0; c1v3p = '0; mrv3p = '0; a0v3p = '0; a1v3p = '0;
        c1v4 = '0; mrv4 = '0;
        for (int p = 0; p < 3; p++) begin
            c0v3[p]  = if3.afu_RxPort[p].c0.rspValid;
            c1v3[p]  = if3.afu_RxPort[p].c1.rspValid;
            mrv3[p]  = if3.afu_RxPort[p].c0.mmioRdValid;
            a0v3[p]  = if3.afu_RxPort[p].c0TxAlmFull;
            c0v3p[p] = if3p.afu_RxPort[p].c0.rspValid;
            c1v3p[p] = if3p.afu_RxPort[p].c1.rspValid;
            mrv3p[p] = if3p.afu_RxPort[p].c0.mmioRdValid;
            a0v3p[p] = if3p.afu_RxPort[p].c0TxAlmFull;
            a1v3p[p] = if3p.afu_RxPort[p].c1TxAlmFull;
        end
        for (int p = 0; p < 4; p++) begin
            c1v4[p] = if4.afu_RxPort[p].c1.rspValid;
            mrv4[p] = if4.afu_RxPort[p].c0.mmioRdValid;
        end
    end

    task automatic drive_idle();
        up = '0;
    endtask

    task automatic apply_reset();
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset();
        int ones, split;
        logic seen0;
        drive_idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (if3.afu_SoftReset !== 3'b111) begin errors++; $display("FAIL reset_srst3 got=%b exp=111", if3.afu_SoftReset); end
        checks++; if (if4.afu_SoftReset !== 4'b1111) begin errors++; $display("FAIL reset_srst4 got=%b exp=1111", if4.afu_SoftReset); end
        checks++; if ((c0v3 | c1v3 | mrv3) !== 3'b000) begin errors++; $display("FAIL reset_valids got=%b exp=000", c0v3 | c1v3 | mrv3); end
        checks++; if (a0v3 !== 3'b111 || a1v3p !== 3'b111) begin errors++; $display("FAIL reset_almfull got=%b/%b exp=111/111", a0v3, a1v3p); end
        checks++; if (if3.route_err !== 1'b0) begin errors++; $display("FAIL reset_route_err got=%b exp=0", if3.route_err); end
        checks++; if (if3.drop_cnt !== 16'h0) begin errors++; $display("FAIL reset_drop_cnt got=%h exp=0000", if3.drop_cnt); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ones = 0; split = 0; seen0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (if3.afu_SoftReset === 3'b111) begin
                if (seen0) split++; else ones++;
            end else if (if3.afu_SoftReset === 3'b000) seen0 = 1'b1;
            else split++;
            @(negedge clk);
        end
        checks++; if (ones !== 16) begin errors++; $display("FAIL reset_hold_len got=%0d exp=16", ones); end
        checks++; if (split !== 0) begin errors++; $display("FAIL reset_release_together got=%0d exp=0", split); end
        checks++; if (if3.afu_SoftReset !== 3'b000) begin errors++; $display("FAIL reset_released got=%b exp=000", if3.afu_SoftReset); end
    endtask

    task automatic test_c0_rsp();
        apply_reset();
        up.c0.rspValid = 1'b1;
        up.c0.hdr      = 28'h0A54012;
        up.c0.data     = {16{32'h1234_5678}};
        @(negedge clk);
        checks++; if (c0v3 !== 3'b010) begin errors++; $display("FAIL c0_port got=%b exp=010", c0v3); end
        checks++; if (if3.afu_RxPort[1].c0.hdr !== 28'h0A50012) begin errors++; $display("FAIL c0_hdr got=%h exp=0a50012", if3.afu_RxPort[1].c0.hdr); end
        checks++; if (if3.afu_RxPort[0].c0.hdr !== 28'h0A50012) begin errors++; $display("FAIL c0_hdr_unsel got=%h exp=0a50012", if3.afu_RxPort[0].c0.hdr); end
        checks++; if (if3.afu_RxPort[1].c0.data !== {16{32'h1234_5678}}) begin errors++; $display("FAIL c0_data got=%h", if3.afu_RxPort[1].c0.data[63:0]); end
        checks++; if ((c1v3 | mrv3) !== 3'b000) begin errors++; $display("FAIL c0_other_valids got=%b exp=000", c1v3 | mrv3); end
        drive_idle();
        @(negedge clk);
        checks++; if (c0v3 !== 3'b000) begin errors++; $display("FAIL c0_single_beat got=%b exp=000", c0v3); end
    endtask

    task automatic test_c1_rsp();
        apply_reset();
        up.c1.rspValid = 1'b1;
        up.c1.hdr      = 28'h080C000;
        @(negedge clk);
        drive_idle();
        checks++; if (c1v4 !== 4'b1000) begin errors++; $display("FAIL c1_n4_port got=%b exp=1000", c1v4); end
        checks++; if (if4.afu_RxPort[3].c1.hdr !== 28'h0800000) begin errors++; $display("FAIL c1_n4_hdr got=%h exp=0800000", if4.afu_RxPort[3].c1.hdr); end
        checks++; if (c1v3 !== 3'b000) begin errors++; $display("FAIL c1_n3_dropped got=%b exp=000", c1v3); end
        repeat (2) @(negedge clk);
        checks++; if (if3.route_err !== 1'b1) begin errors++; $display("FAIL c1_n3_route_err got=%b exp=1", if3.route_err); end
        checks++; if (if3.drop_cnt !== 16'd1) begin errors++; $display("FAIL c1_n3_drop_cnt got=%h exp=0001", if3.drop_cnt); end
        checks++; if (if4.route_err !== 1'b0 || if4.drop_cnt !== 16'd0) begin errors++; $display("FAIL c1_n4_no_err got=%b/%h exp=0/0000", if4.route_err, if4.drop_cnt); end
    endtask

    task automatic test_mmio();
        t_ccip_c0_mmio_hdr m, g;
        apply_reset();
        m = '0;
        m.address = 16'h2040;
        m.tid     = 9'h1A5;
        up.c0.mmioRdValid = 1'b1;
        up.c0.hdr         = m;
        @(negedge clk);
        g = if3.afu_RxPort[2].c0.hdr;
        checks++; if (mrv3 !== 3'b100) begin errors++; $display("FAIL mmio_port got=%b exp=100", mrv3); end
        checks++; if (g.address !== 16'h0040) begin errors++; $display("FAIL mmio_addr got=%h exp=0040", g.address); end
        checks++; if (g.tid !== 9'h1A5) begin errors++; $display("FAIL mmio_tid got=%h exp=1a5", g.tid); end
        m.address = 16'h3000;
        m.tid     = 9'h0C3;
        up.c0.hdr = m;
        @(negedge clk);
        drive_idle();
        g = if3.afu_RxPort[0].c0.hdr;
        checks++; if (mrv3 !== 3'b001) begin errors++; $display("FAIL mmio_oow_port got=%b exp=001", mrv3); end
        checks++; if (g.address !== 16'h3000 || g.tid !== 9'h0C3) begin errors++; $display("FAIL mmio_oow_hdr got=%h/%h exp=3000/0c3", g.address, g.tid); end
        g = if4.afu_RxPort[3].c0.hdr;
        checks++; if (mrv4 !== 4'b1000 || g.address !== 16'h0000) begin errors++; $display("FAIL mmio_n4 got=%b/%h exp=1000/0000", mrv4, g.address); end
        repeat (2) @(negedge clk);
        checks++; if (if3.route_err !== 1'b1) begin errors++; $display("FAIL mmio_route_err got=%b exp=1", if3.route_err); end
        checks++; if (if3.drop_cnt !== 16'd0) begin errors++; $display("FAIL mmio_no_drop got=%h exp=0000", if3.drop_cnt); end
        checks++; if (if4.route_err !== 1'b0) begin errors++; $display("FAIL mmio_n4_no_err got=%b exp=0", if4.route_err); end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        up.c0.rspValid = 1'b1; up.c0.hdr = 28'h0000011;
        up.c1.rspValid = 1'b1; up.c1.hdr = 28'h0008022;
        @(negedge clk);
        checks++; if (c0v3 !== 3'b001 || c1v3 !== 3'b100) begin errors++; $display("FAIL same_cycle_diff got=%b/%b exp=001/100", c0v3, c1v3); end
        checks++; if (if3.afu_RxPort[2].c1.hdr !== 28'h0000022) begin errors++; $display("FAIL same_cycle_c1_hdr got=%h exp=0000022", if3.afu_RxPort[2].c1.hdr); end
        up.c0.hdr = 28'h0004033;
        up.c1.hdr = 28'h0004044;
        @(negedge clk);
        checks++; if (c0v3 !== 3'b010 || c1v3 !== 3'b010) begin errors++; $display("FAIL same_cycle_same_port got=%b/%b exp=010/010", c0v3, c1v3); end
        up.c0.hdr = 28'h000C001;
        up.c1.hdr = 28'h000C002;
        @(negedge clk);
        drive_idle();
        checks++; if ((c0v3 | c1v3) !== 3'b000) begin errors++; $display("FAIL double_drop_valids got=%b exp=000", c0v3 | c1v3); end
        repeat (2) @(negedge clk);
        checks++; if (if3.drop_cnt !== 16'd2) begin errors++; $display("FAIL double_drop_cnt got=%h exp=0002", if3.drop_cnt); end
        checks++; if (if3.route_err !== 1'b1) begin errors++; $display("FAIL double_drop_err got=%b exp=1", if3.route_err); end
    endtask

    task automatic test_pipe_latency();
        t_ccip_c0_mmio_hdr m;
        logic [2:0] e_c0, e_c1, e_mr, e_a0, e_a1;
        apply_reset();
        up.c0TxAlmFull = 1'b1;
        up.c0.rspValid = 1'b1; up.c0.hdr = 28'h0004000;
        up.c1.rspValid = 1'b1; up.c1.hdr = 28'h0008000;
        @(negedge clk);
        checks++; if (c0v3 !== 3'b010) begin errors++; $display("FAIL pipe_ref_n0 got=%b exp=010", c0v3); end
        for (int k = 1; k <= 5; k++) begin
            e_c0 = (k == 3) ? 3'b010 : 3'b000;
            e_c1 = (k == 3) ? 3'b100 : 3'b000;
            e_a0 = (k == 3) ? 3'b111 : 3'b000;
            e_mr = (k == 4) ? 3'b010 : 3'b000;
            e_a1 = (k == 4) ? 3'b111 : 3'b000;
            checks++; if (c0v3p !== e_c0) begin errors++; $display("FAIL pipe_c0 k=%0d got=%b exp=%b", k, c0v3p, e_c0); end
            checks++; if (c1v3p !== e_c1) begin errors++; $display("FAIL pipe_c1 k=%0d got=%b exp=%b", k, c1v3p, e_c1); end
            checks++; if (mrv3p !== e_mr) begin errors++; $display("FAIL pipe_mmio k=%0d got=%b exp=%b", k, mrv3p, e_mr); end
            checks++; if (a0v3p !== e_a0) begin errors++; $display("FAIL pipe_c0alm k=%0d got=%b exp=%b", k, a0v3p, e_a0); end
            checks++; if (a1v3p !== e_a1) begin errors++; $display("FAIL pipe_c1alm k=%0d got=%b exp=%b", k, a1v3p, e_a1); end
            if (k == 1) begin
                drive_idle();
                m = '0;
                m.address = 16'h1040;
                up.c1TxAlmFull    = 1'b1;
                up.c0.mmioRdValid = 1'b1;
                up.c0.hdr         = m;
            end else if (k == 2) begin
                drive_idle();
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        int ones;
        logic seen0;
        apply_reset();
        up.c0.rspValid = 1'b1;
        up.c0.hdr      = 28'h0004001;
        repeat (4) @(negedge clk);
        checks++; if (c0v3 !== 3'b010 || c0v3p !== 3'b010) begin errors++; $display("FAIL burst_flowing got=%b/%b exp=010/010", c0v3, c0v3p); end
        checks++; if (if3.afu_SoftReset !== 3'b000) begin errors++; $display("FAIL burst_pre_srst got=%b exp=000", if3.afu_SoftReset); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (c0v3 !== 3'b000 || c0v3p !== 3'b000) begin errors++; $display("FAIL async_valids got=%b/%b exp=000/000", c0v3, c0v3p); end
        checks++; if (a0v3p !== 3'b111) begin errors++; $display("FAIL async_almfull got=%b exp=111", a0v3p); end
        checks++; if (if3p.afu_SoftReset !== 3'b111) begin errors++; $display("FAIL async_srst got=%b exp=111", if3p.afu_SoftReset); end
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        ones = 0; seen0 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            #1;
            if (if3p.afu_SoftReset === 3'b111 && !seen0) ones++;
            else seen0 = 1'b1;
            @(negedge clk);
        end
        checks++; if (ones !== 16) begin errors++; $display("FAIL async_hold_restart got=%0d exp=16", ones); end
    endtask

    task automatic test_drop_sat();
        apply_reset();
        up.c0.rspValid = 1'b1; up.c0.hdr = 28'h000C000;
        up.c1.rspValid = 1'b1; up.c1.hdr = 28'h000C000;
        repeat (32767) @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (if3.drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload got=%h exp=fffe", if3.drop_cnt); end
        checks++; if (if3p.drop_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload_p2 got=%h exp=fffe", if3p.drop_cnt); end
        checks++; if (if4.drop_cnt !== 16'h0000) begin errors++; $display("FAIL sat_n4_none got=%h exp=0000", if4.drop_cnt); end
        up.c0.rspValid = 1'b1; up.c0.hdr = 28'h000C000;
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (if3.drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach_max got=%h exp=ffff", if3.drop_cnt); end
        up.c0.rspValid = 1'b1; up.c0.hdr = 28'h000C000;
        up.c1.rspValid = 1'b1; up.c1.hdr = 28'h000C000;
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        checks++; if (if3.drop_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold_max got=%h exp=ffff", if3.drop_cnt); end
        checks++; if (if3.route_err !== 1'b1) begin errors++; $display("FAIL sat_route_err got=%b exp=1", if3.route_err); end
    endtask

    initial begin
        rst_n = 1'b0;
        up    = '0;
        test_reset();
        test_c0_rsp();
        test_c1_rsp();
        test_mmio();
        test_same_cycle();
        test_pipe_latency();
        test_async_reset();
        test_drop_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
